// File: rtl/hc595_pkg.sv
// Shared constants, FSM encoding and frame bit-order helpers for the 74HC595 serialiser.
package hc595_pkg;

  localparam int FRAME_BITS = 14;
  localparam int SEG_W      = 8;
  localparam int SEL_W      = 6;
  localparam int BIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  function automatic int half_of(input int clk_div);
    return clk_div / 2;
  endfunction

  // Frame is {seg, sel}: slots 0..7 carry seg LSB first, slots 8..13 carry sel MSB first.
  function automatic logic frame_bit(input logic [FRAME_BITS-1:0] frame,
                                     input logic [BIT_W-1:0]      slot);
    logic w_bit;
    if (slot < 4'd8) begin
      w_bit = frame[slot + 4'd6];
    end else begin
      w_bit = frame[4'd13 - slot];
    end
    return w_bit;
  endfunction

endpackage

// File: rtl/hc595_slot_timer.sv
// Slot timing for the 595 serialiser: divides sys_clk into bit slots and counts slots per frame.
// Strobes announce the cycle that follows, so the consumer can register its outputs one cycle early.
module hc595_slot_timer
  import hc595_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_bit_en,
  output logic             o_slot_start,
  output logic             o_slot_half,
  output logic             o_slot_last,
  output logic             o_bit_last,
  output logic [BIT_W-1:0] o_cnt_bit
);

  localparam int               DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX      = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PENULT   = DIV_W'(CLK_DIV - 2);
  localparam logic [DIV_W-1:0] DIV_PRE_HALF = DIV_W'(half_of(CLK_DIV) - 1);
  localparam logic [BIT_W-1:0] BIT_MAX      = BIT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0] r_cnt_div;
  logic [BIT_W-1:0] r_cnt_bit;
  logic             w_div_wrap;

  assign w_div_wrap = (r_cnt_div == DIV_MAX);

  // Divider and slot counters; both are held at zero while the FSM is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_div <= '0;
      r_cnt_bit <= '0;
    end else if (!i_run) begin
      r_cnt_div <= '0;
      r_cnt_bit <= '0;
    end else begin
      r_cnt_div <= w_div_wrap ? '0 : r_cnt_div + 1'b1;
      if (i_bit_en && w_div_wrap) begin
        r_cnt_bit <= (r_cnt_bit == BIT_MAX) ? '0 : r_cnt_bit + 1'b1;
      end else begin
        r_cnt_bit <= r_cnt_bit;
      end
    end
  end

  assign o_slot_start = !i_run || w_div_wrap;
  assign o_slot_half  = i_run && (r_cnt_div == DIV_PRE_HALF);
  assign o_slot_last  = i_run && (r_cnt_div == DIV_PENULT);
  assign o_bit_last   = (r_cnt_bit == BIT_MAX);
  assign o_cnt_bit    = r_cnt_bit;

endmodule

// File: rtl/hc595_ctrl.sv
// Continuous {seg, sel} serialiser for two cascaded 74HC595s: IDLE -> SHIFT x14 slots -> LATCH.
// Build option HC595_BLANK_EN keeps oe high (blanked) until the first frame has been latched.
module hc595_ctrl
  import hc595_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEG_W-1:0] seg,
  output logic             ds,
  output logic             shcp,
  output logic             stcp,
  output logic             oe,
  output logic             frame_done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] r_shadow;
  logic [FRAME_BITS-1:0] w_shadow_nxt;
  logic                  r_ds;
  logic                  w_ds_nxt;
  logic                  r_shcp;
  logic                  w_shcp_nxt;
  logic                  r_stcp;
  logic                  w_stcp_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;
  logic                  r_oe;

  logic                  w_slot_start;
  logic                  w_slot_half;
  logic                  w_slot_last;
  logic                  w_bit_last;
  logic [BIT_W-1:0]      w_cnt_bit;

  hc595_slot_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_slot_timer (
    .i_clk        (sys_clk),
    .i_rst_n      (sys_rst_n),
    .i_run        (r_state != IDLE),
    .i_bit_en     (r_state == SHIFT),
    .o_slot_start (w_slot_start),
    .o_slot_half  (w_slot_half),
    .o_slot_last  (w_slot_last),
    .o_bit_last   (w_bit_last),
    .o_cnt_bit    (w_cnt_bit)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next output levels, computed for the cycle the timer strobes announce.
  always_comb begin
    w_state_nxt      = r_state;
    w_shadow_nxt     = r_shadow;
    w_ds_nxt         = r_ds;
    w_shcp_nxt       = r_shcp;
    w_stcp_nxt       = r_stcp;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt  = SHIFT;
        w_shadow_nxt = {seg, sel};
        w_ds_nxt     = frame_bit({seg, sel}, 4'd0);
        w_shcp_nxt   = 1'b0;
        w_stcp_nxt   = 1'b0;
      end
      SHIFT: begin
        w_stcp_nxt = 1'b0;
        if (w_slot_half) begin
          w_shcp_nxt = 1'b1;
        end else if (w_slot_start) begin
          w_shcp_nxt = 1'b0;
          if (w_bit_last) begin
            w_state_nxt = LATCH;
            w_ds_nxt    = 1'b0;
          end else begin
            w_ds_nxt = frame_bit(r_shadow, w_cnt_bit + 4'd1);
          end
        end else begin
          w_shcp_nxt = r_shcp;
        end
      end
      LATCH: begin
        w_ds_nxt         = 1'b0;
        w_shcp_nxt       = 1'b0;
        w_frame_done_nxt = w_slot_last;
        if (w_slot_half) begin
          w_stcp_nxt = 1'b1;
        end else if (w_slot_start) begin
          w_stcp_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_stcp_nxt = r_stcp;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ds_nxt    = 1'b0;
        w_shcp_nxt  = 1'b0;
        w_stcp_nxt  = 1'b0;
      end
    endcase
  end

  // Shadow copy of the frame and the registered 595 interface.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shadow     <= '0;
      r_ds         <= 1'b0;
      r_shcp       <= 1'b0;
      r_stcp       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_shadow     <= w_shadow_nxt;
      r_ds         <= w_ds_nxt;
      r_shcp       <= w_shcp_nxt;
      r_stcp       <= w_stcp_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

`ifdef HC595_BLANK_EN
  // Output enable: blanked from reset until the cycle after the first latched frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_oe <= 1'b1;
    end else if (r_frame_done) begin
      r_oe <= 1'b0;
    end else begin
      r_oe <= r_oe;
    end
  end
`else
  // Output enable: permanently enabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_oe <= 1'b0;
    end else begin
      r_oe <= 1'b0;
    end
  end
`endif

  assign ds         = r_ds;
  assign shcp       = r_shcp;
  assign stcp       = r_stcp;
  assign oe         = r_oe;
  assign frame_done = r_frame_done;

endmodule
